// File: rtl/sync_debounce_pkg.sv
// Shared FSM state encodings and elaboration-time helpers for the debouncer.
package sync_debounce_pkg;

    localparam logic [1:0] ST_STABLE_LO = 2'd0;
    localparam logic [1:0] ST_CHECK_HI  = 2'd1;
    localparam logic [1:0] ST_STABLE_HI = 2'd2;
    localparam logic [1:0] ST_CHECK_LO  = 2'd3;

    // Ceiling log2, minimum 1 so a counter is never zero bits wide.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_debounce_sat_counter.sv
// Saturating event counter: clear wins over hold, but an event in the clear cycle is kept.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear to 0 (or 1 if an event coincides), else increment until all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sync_debounce.sv
// Debouncer for an already-synchronized level: clean level, edge pulses, event counters.
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EVT_W           = 8,
    parameter bit          RESET_LEVEL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_syn,
    input  logic             evt_clr,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [EVT_W-1:0] rise_cnt,
    output logic [EVT_W-1:0] fall_cnt,
    output logic [EVT_W-1:0] glitch_cnt
);

    localparam int unsigned      RUN_W     = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       RST_STATE = RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;

    logic [1:0]       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             rise_inc_c, fall_inc_c, glitch_inc_c;

    // Next-state, run counter, accepted-edge and event-increment decode.
    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        level_d      = level_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        rise_inc_c   = 1'b0;
        fall_inc_c   = 1'b0;
        glitch_inc_c = 1'b0;
        case (state_q)
            ST_STABLE_LO: begin
                run_d = '0;
                if (in_syn) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d    = ST_STABLE_HI;
                        level_d    = 1'b1;
                        rise_d     = 1'b1;
                        rise_inc_c = 1'b1;
                    end else begin
                        state_d = ST_CHECK_HI;
                        run_d   = RUN_W'(1);
                    end
                end
            end
            ST_CHECK_HI: begin
                if (!in_syn) begin
                    state_d      = ST_STABLE_LO;
                    run_d        = '0;
                    glitch_inc_c = 1'b1;
                end else if (run_q == RUN_LAST) begin
                    state_d    = ST_STABLE_HI;
                    run_d      = '0;
                    level_d    = 1'b1;
                    rise_d     = 1'b1;
                    rise_inc_c = 1'b1;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end
            ST_STABLE_HI: begin
                run_d = '0;
                if (!in_syn) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d    = ST_STABLE_LO;
                        level_d    = 1'b0;
                        fall_d     = 1'b1;
                        fall_inc_c = 1'b1;
                    end else begin
                        state_d = ST_CHECK_LO;
                        run_d   = RUN_W'(1);
                    end
                end
            end
            default: begin
                if (in_syn) begin
                    state_d      = ST_STABLE_HI;
                    run_d        = '0;
                    glitch_inc_c = 1'b1;
                end else if (run_q == RUN_LAST) begin
                    state_d    = ST_STABLE_LO;
                    run_d      = '0;
                    level_d    = 1'b0;
                    fall_d     = 1'b1;
                    fall_inc_c = 1'b1;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end
        endcase
    end

    // FSM, run counter and output registers; reset discards any pending transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            run_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    sat_counter #(.W(EVT_W)) u_rise_cnt (
        .clk (clk),
        .rst (rst),
        .clr (evt_clr),
        .inc (rise_inc_c),
        .cnt (rise_cnt)
    );

    sat_counter #(.W(EVT_W)) u_fall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (evt_clr),
        .inc (fall_inc_c),
        .cnt (fall_cnt)
    );

    sat_counter #(.W(EVT_W)) u_glitch_cnt (
        .clk (clk),
        .rst (rst),
        .clr (evt_clr),
        .inc (glitch_inc_c),
        .cnt (glitch_cnt)
    );

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboarded bench: two debouncers (N=4 reset-low, N=1 reset-high) on a shared input.
module tb_sync_debounce;

    localparam int NC0 = 4;
    localparam int NC1 = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_syn = 1'b0;
    logic       evt_clr = 1'b0;

    logic       lvl0, rp0, fp0, lvl1, rp1, fp1;
    logic [3:0] rc0, fc0, gc0, rc1, fc1, gc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_debounce #(.DEBOUNCE_CYCLES(NC0), .EVT_W(4), .RESET_LEVEL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_syn(in_syn), .evt_clr(evt_clr),
        .level_out(lvl0), .rise_pulse(rp0), .fall_pulse(fp0),
        .rise_cnt(rc0), .fall_cnt(fc0), .glitch_cnt(gc0)
    );

    sync_debounce #(.DEBOUNCE_CYCLES(NC1), .EVT_W(4), .RESET_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_syn(in_syn), .evt_clr(evt_clr),
        .level_out(lvl1), .rise_pulse(rp1), .fall_pulse(fp1),
        .rise_cnt(rc1), .fall_cnt(fc1), .glitch_cnt(gc1)
    );

    // Expected outputs after one clock edge: {level, rise, fall, rise_cnt, fall_cnt, glitch_cnt}.
    typedef struct packed {
        logic [14:0] e0;
        logic [14:0] e1;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: a new level is accepted once the input has disagreed with
    // the current level on N consecutive samples; any return early is a glitch.
    bit         m_lvl    [2];
    int         m_streak [2];
    logic [3:0] m_rc [2], m_fc [2], m_gc [2];
    bit         m_rise [2], m_fall [2];
    bit         started = 1'b0;

    function automatic logic [3:0] sat_next(input logic [3:0] c, input bit inc, input bit clr);
        if (clr) return inc ? 4'd1 : 4'd0;
        if (inc) return (c == 4'd15) ? c : c + 4'd1;
        return c;
    endfunction

    function automatic logic [14:0] pack_exp(input int i);
        return {m_lvl[i], m_rise[i], m_fall[i], m_rc[i], m_fc[i], m_gc[i]};
    endfunction

    task automatic model_reset();
        m_lvl[0] = 1'b0;
        m_lvl[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_streak[i] = 0;
            m_rc[i] = '0; m_fc[i] = '0; m_gc[i] = '0;
            m_rise[i] = 1'b0; m_fall[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit s, input bit clr);
        int n;
        bit acc, gl;
        for (int i = 0; i < 2; i++) begin
            n   = (i == 0) ? NC0 : NC1;
            acc = 1'b0;
            gl  = 1'b0;
            if (s != m_lvl[i]) begin
                m_streak[i]++;
                if (m_streak[i] >= n) begin
                    acc         = 1'b1;
                    m_lvl[i]    = s;
                    m_streak[i] = 0;
                end
            end else begin
                gl          = (m_streak[i] > 0);
                m_streak[i] = 0;
            end
            m_rise[i] = acc && s;
            m_fall[i] = acc && !s;
            m_rc[i]   = sat_next(m_rc[i], m_rise[i], clr);
            m_fc[i]   = sat_next(m_fc[i], m_fall[i], clr);
            m_gc[i]   = sat_next(m_gc[i], gl, clr);
        end
    endtask

    // Issue side: advance the model every edge and queue the expected response.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            started = 1'b1;
            model_reset();
            sb_q.delete();
            sb_q.push_back('{e0: pack_exp(0), e1: pack_exp(1)});
        end else if (started) begin
            model_step(in_syn, evt_clr);
            sb_q.push_back('{e0: pack_exp(0), e1: pack_exp(1)});
        end
    end

    // Check side: on the falling edge pop one expectation and compare both DUTs.
    always @(negedge clk) begin
        exp_t        e;
        logic [14:0] a0, a1;
        if (sb_q.size() != 0) begin
            e  = sb_q.pop_front();
            a0 = {lvl0, rp0, fp0, rc0, fc0, gc0};
            a1 = {lvl1, rp1, fp1, rc1, fc1, gc1};
            checks++;
            if (a0 !== e.e0) begin
                errors++;
                $display("FAIL sb_dut0 t=%0t got lvl/r/f=%b%b%b rc=%0d fc=%0d gc=%0d want lvl/r/f=%b%b%b rc=%0d fc=%0d gc=%0d",
                         $time, a0[14], a0[13], a0[12], a0[11:8], a0[7:4], a0[3:0],
                         e.e0[14], e.e0[13], e.e0[12], e.e0[11:8], e.e0[7:4], e.e0[3:0]);
            end
            checks++;
            if (a1 !== e.e1) begin
                errors++;
                $display("FAIL sb_dut1 t=%0t got lvl/r/f=%b%b%b rc=%0d fc=%0d gc=%0d want lvl/r/f=%b%b%b rc=%0d fc=%0d gc=%0d",
                         $time, a1[14], a1[13], a1[12], a1[11:8], a1[7:4], a1[3:0],
                         e.e1[14], e.e1[13], e.e1[12], e.e1[11:8], e.e1[7:4], e.e1[3:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Assert reset between edges and check that it takes hold before the next edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_level0", 32'(lvl0), 32'd0);
        chk("rst_pulses0", 32'({rp0, fp0}), 32'd0);
        chk("rst_counts0", 32'({rc0, fc0, gc0}), 32'd0);
        chk("rst_level1", 32'(lvl1), 32'd1);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int hold;

        // Reset mid-clock while the input is high.
        in_syn = 1'b1;
        tick(2);
        #2;
        do_reset();
        in_syn = 1'b0;
        tick(3);

        // Clean rise: level appears after exactly four high samples.
        in_syn = 1'b1;
        tick(3);
        chk("rise_not_yet", 32'(lvl0), 32'd0);
        tick();
        chk("rise_level", 32'(lvl0), 32'd1);
        chk("rise_pulse", 32'(rp0), 32'd1);
        tick();
        chk("rise_pulse_end", 32'(rp0), 32'd0);
        chk("rise_cnt1", 32'(rc0), 32'd1);
        tick(5);
        in_syn = 1'b0;
        tick(4);
        chk("fall_pulse", 32'(fp0), 32'd1);
        chk("fall_level", 32'(lvl0), 32'd0);
        chk("fall_cnt1", 32'(fc0), 32'd1);
        tick(5);

        // Glitches: three high samples then low, repeated until saturation.
        for (int k = 0; k < 20; k++) begin
            in_syn = 1'b1;
            tick(3);
            in_syn = 1'b0;
            tick(3);
            if (k == 0) begin
                chk("glitch_cnt1", 32'(gc0), 32'd1);
                chk("glitch_level", 32'(lvl0), 32'd0);
            end
        end
        chk("glitch_sat", 32'(gc0), 32'd15);

        // Rise counter saturation.
        for (int k = 0; k < 17; k++) begin
            in_syn = 1'b1;
            tick(5);
            in_syn = 1'b0;
            tick(5);
        end
        chk("rise_sat", 32'(rc0), 32'd15);

        // Clear alone.
        evt_clr = 1'b1;
        tick();
        evt_clr = 1'b0;
        chk("clr_counts", 32'({rc0, fc0, gc0}), 32'd0);

        // Clear in the same cycle as an accepted rise keeps the event.
        in_syn = 1'b1;
        tick(5);
        in_syn = 1'b0;
        tick(5);
        in_syn = 1'b1;
        tick(3);
        evt_clr = 1'b1;
        tick();
        evt_clr = 1'b0;
        chk("clr_with_rise", 32'(rc0), 32'd1);
        chk("clr_with_rise_pulse", 32'(rp0), 32'd1);
        in_syn = 1'b0;
        tick(6);

        // Reset during a pending rise discards it.
        in_syn = 1'b1;
        tick(2);
        do_reset();
        tick(3);
        chk("rstmid_not_yet", 32'({lvl0, rp0}), 32'd0);
        tick();
        chk("rstmid_rise", 32'({lvl0, rp0}), 32'd3);
        in_syn = 1'b0;
        tick(6);

        // Random run lengths, sporadic clears and resets.
        hold = 0;
        for (int k = 0; k < 3000; k++) begin
            if (hold == 0) begin
                in_syn = 1'($urandom_range(0, 1));
                hold   = int'($urandom_range(1, 7));
            end
            hold--;
            evt_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end
        evt_clr = 1'b0;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
